// File: rtl/ddr_frame_reader_pkg.sv
// frame_reader_pkg: shared types and AXI constants for ddr_frame_reader.
//   fr_state_t      - fetch FSM states
//   AXI_BURST_INCR  - ARBURST encoding for incrementing bursts
//   AXI_SIZE_4B     - ARSIZE encoding for 4-byte beats
//   AXI_RESP_OKAY   - RRESP value that is not an error
package frame_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ADDR,
    DATA,
    DONE
  } fr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ddr_frame_reader_if.sv
// ddr_frame_reader_if: AXI4 read-only channels (AR + R) between the frame
// reader and the DDR interconnect.
//   master modport - the frame reader (drives AR, accepts R)
//   slave  modport - the memory / interconnect side
interface ddr_frame_reader_if;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/ddr_frame_reader_fifo.sv
// frame_fifo: synchronous first-word-fall-through FIFO.
//   clk_i, rst_i      - clock, async active-high reset
//   push_i, data_i    - write side (ignored when full)
//   pop_i, data_o     - read side; data_o shows the head entry, zero when empty
//   full_o, empty_o   - occupancy flags
//   free_cnt_o        - number of free entries
module frame_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign free_cnt_o = CW'(DEPTH) - count_q;
  // Forcing zero when empty keeps the pixel bus at a defined value after reset.
  assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: fetches one frame from DDR with AXI4 INCR read bursts and
// streams it out as 24-bit pixels through a FWFT FIFO.
//   clk_i, rst_i         - clock, async active-high reset
//   start_i              - begin a frame fetch (ignored while busy_o)
//   m_axi                - AXI read channels (master modport)
//   pix_data_o/sof/valid - pixel stream out, pix_ready_i back-pressure
//   busy_o, done_o       - fetch in progress, one-cycle end-of-frame pulse
//   err_o                - sticky RRESP / RLAST error, cleared on start
// Build option: define FRAME_READER_LOOP_EN to refetch frames continuously.
module ddr_frame_reader
  import frame_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FRAME_WORDS = 1280*720,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_DEPTH  = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  ddr_frame_reader_if.master        m_axi,
  output logic [23:0]               pix_data_o,
  output logic                      pix_sof_o,
  output logic                      pix_valid_o,
  input  logic                      pix_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);
  localparam int RW  = $clog2(FRAME_WORDS+1);
  localparam int FCW = $clog2(FIFO_DEPTH+1);

  fr_state_t      state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [RW-1:0]  remain_q, remain_d;
  logic [7:0]     beat_q, beat_d;
  logic [7:0]     arlen_q, arlen_d;
  logic           sof_q, sof_d;
  logic           err_q, err_d;

  logic           fifo_push, fifo_empty, fifo_full;
  logic [24:0]    fifo_rdata;
  logic [FCW-1:0] free_cnt;
  logic           beat_last;
  logic           unused_rdata;

  assign beat_last    = (beat_q == arlen_q);
  assign unused_rdata = &{1'b0, m_axi.m_axi_rdata[31:24], fifo_full};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    beat_d    = beat_q;
    arlen_d   = arlen_q;
    sof_d     = sof_q;
    err_d     = err_q;
    fifo_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = WAIT;
          addr_d   = BASE_ADDR;
          remain_d = RW'(FRAME_WORDS);
          beat_d   = '0;
          sof_d    = 1'b1;
          err_d    = 1'b0;
        end
      end
      WAIT: begin
        // Reserving a full burst of space up front means rready never drops mid-burst.
        if (32'(free_cnt) >= 32'(BURST_LEN)) begin
          state_d = ADDR;
          arlen_d = (32'(remain_q) >= 32'(BURST_LEN)) ? 8'(BURST_LEN - 1)
                                                      : 8'(32'(remain_q) - 32'd1);
        end
      end
      ADDR: begin
        if (m_axi.m_axi_arready) state_d = DATA;
      end
      DATA: begin
        if (m_axi.m_axi_rvalid) begin
          fifo_push = 1'b1;
          sof_d     = 1'b0;
          remain_d  = remain_q - RW'(1);
          if (m_axi.m_axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
          // Our own beat count ends the burst; rlast is only cross-checked.
          if (m_axi.m_axi_rlast != beat_last) err_d = 1'b1;
          if (beat_last) begin
            beat_d  = '0;
            addr_d  = addr_q + ((32'(arlen_q) + 32'd1) << 2);
            state_d = (remain_q == RW'(1)) ? DONE : WAIT;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      DONE: begin
`ifdef FRAME_READER_LOOP_EN
        state_d  = WAIT;
        addr_d   = BASE_ADDR;
        remain_d = RW'(FRAME_WORDS);
        beat_d   = '0;
        sof_d    = 1'b1;
`else
        state_d  = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= BASE_ADDR;
      remain_q <= '0;
      beat_q   <= '0;
      arlen_q  <= '0;
      sof_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      beat_q   <= beat_d;
      arlen_q  <= arlen_d;
      sof_q    <= sof_d;
      err_q    <= err_d;
    end
  end

  frame_fifo #(
    .WIDTH (25),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .data_i     ({sof_q, m_axi.m_axi_rdata[23:0]}),
    .pop_i      (pix_ready_i),
    .data_o     (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .free_cnt_o (free_cnt)
  );

  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arlen   = arlen_q;
  assign m_axi.m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi.m_axi_arburst = AXI_BURST_INCR;
  assign m_axi.m_axi_arvalid = (state_q == ADDR);
  assign m_axi.m_axi_rready  = (state_q == DATA);

  assign pix_valid_o = !fifo_empty;
  assign pix_data_o  = fifo_rdata[23:0];
  assign pix_sof_o   = fifo_rdata[24];
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
endmodule

// File: tb/tb_ddr_frame_reader.sv
`timescale 1ns/1ps
module tb_ddr_frame_reader;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int FW = 72;
  localparam int BL = 16;
  localparam int FD = 64;
  localparam int NBURST = (FW + BL - 1) / BL;

  logic clk = 1'b0;
  logic rst, start;
  logic [23:0] pix_data;
  logic pix_sof, pix_valid, pix_ready, busy, done, err;

  always #5 clk = ~clk;

  ddr_frame_reader_if axi_if ();

  ddr_frame_reader #(
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FW),
    .BURST_LEN   (BL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .m_axi       (axi_if),
    .pix_data_o  (pix_data),
    .pix_sof_o   (pix_sof),
    .pix_valid_o (pix_valid),
    .pix_ready_i (pix_ready),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Frame contents in "DDR" and slave/sink controls.
  logic [31:0] mem [FW];
  int   ar_delay = 0;
  int   bad_resp_beat = -1;
  int   early_last_beat = -1;
  int   ready_mode = 1;        // 0 held low, 1 always high, 2 random
  logic bad_resp_sent = 1'b0;
  logic ar_unstable = 1'b0;

  logic [31:0] ar_addr_q [$];
  logic [7:0]  ar_len_q [$];
  logic [23:0] rx_data [$];
  logic        rx_sof [$];
  int   done_cnt = 0;
  logic busy_bad = 1'b0;

  // AXI read slave: one burst at a time, random rvalid gaps.
  initial begin : axi_slave
    int phase, beat, waited, idx;
    logic seen;
    logic [31:0] cur_addr;
    logic [7:0]  cur_len;
    phase = 0; beat = 0; waited = 0; seen = 1'b0;
    cur_addr = '0; cur_len = '0;
    axi_if.m_axi_arready = 1'b0;
    axi_if.m_axi_rvalid  = 1'b0;
    axi_if.m_axi_rdata   = '0;
    axi_if.m_axi_rresp   = 2'b00;
    axi_if.m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; seen = 1'b0; waited = 0;
        axi_if.m_axi_arready = 1'b0;
        axi_if.m_axi_rvalid  = 1'b0;
        axi_if.m_axi_rlast   = 1'b0;
      end else if (phase == 0) begin
        axi_if.m_axi_rvalid = 1'b0;
        axi_if.m_axi_rlast  = 1'b0;
        axi_if.m_axi_arready = 1'b0;
        if (axi_if.m_axi_arvalid) begin
          if (!seen) begin
            seen = 1'b1; waited = 0;
            cur_addr = axi_if.m_axi_araddr;
            cur_len  = axi_if.m_axi_arlen;
          end else if (axi_if.m_axi_araddr != cur_addr || axi_if.m_axi_arlen != cur_len) begin
            ar_unstable = 1'b1;
          end
          if (waited >= ar_delay) begin
            axi_if.m_axi_arready = 1'b1;
            ar_addr_q.push_back(cur_addr);
            ar_len_q.push_back(cur_len);
            $display("AR handshake: addr=%08h len=%0d", cur_addr, cur_len);
            phase = 1; beat = 0; seen = 1'b0;
          end else begin
            waited++;
          end
        end else if (seen) begin
          ar_unstable = 1'b1;
        end
      end else begin
        axi_if.m_axi_arready = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          axi_if.m_axi_rvalid = 1'b0;
          axi_if.m_axi_rlast  = 1'b0;
        end else begin
          idx = int'((cur_addr - BASE) >> 2) + beat;
          axi_if.m_axi_rdata = mem[idx];
          axi_if.m_axi_rresp = (idx == bad_resp_beat) ? 2'b10 : 2'b00;
          if (idx == bad_resp_beat) bad_resp_sent = 1'b1;
          if (early_last_beat >= 0 && cur_addr == BASE)
            axi_if.m_axi_rlast = (beat == early_last_beat);
          else
            axi_if.m_axi_rlast = (beat == int'(cur_len));
          axi_if.m_axi_rvalid = 1'b1;
          beat++;
          if (beat > int'(cur_len)) phase = 0;
        end
      end
    end
  end

  // Pixel sink: records every accepted pixel and every done pulse.
  initial begin : pix_sink
    pix_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (!rst && pix_valid && pix_ready) begin
        rx_data.push_back(pix_data);
        rx_sof.push_back(pix_sof);
      end
      if (!rst && done) begin
        done_cnt++;
        if (!busy) busy_bad = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: pixel i is word i of the frame, sof only on i==0.
  function automatic int pixel_errors();
    int e = 0;
    for (int i = 0; i < FW; i++) begin
      if (i >= rx_data.size()) e++;
      else if (rx_data[i] !== mem[i][23:0] || rx_sof[i] !== (i == 0)) e++;
    end
    if (rx_data.size() > FW) e += rx_data.size() - FW;
    return e;
  endfunction

  // Reference model: burst b starts at BASE + b*BL*4 with min(BL, left)-1.
  function automatic int ar_errors(int n);
    int e = 0;
    int left;
    if (ar_addr_q.size() != n) e++;
    for (int b = 0; b < n && b < ar_addr_q.size(); b++) begin
      left = FW - b * BL;
      if (ar_addr_q[b] !== BASE + 32'(b * BL * 4)) e++;
      if (ar_len_q[b] !== 8'(((left < BL) ? left : BL) - 1)) e++;
    end
    return e;
  endfunction

  task automatic clear_log();
    ar_addr_q.delete(); ar_len_q.delete();
    rx_data.delete(); rx_sof.delete();
    done_cnt = 0; busy_bad = 1'b0; bad_resp_sent = 1'b0; ar_unstable = 1'b0;
    for (int i = 0; i < FW; i++) mem[i] = $urandom;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int cyc = 0;
    while (cyc < 4000 && !(done_cnt >= 1 && rx_data.size() >= FW)) begin
      @(negedge clk); #2;
      cyc++;
    end
    n_checks++;
    if (cyc >= 4000) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pixels/%0d done, expected %0d/1", name, rx_data.size(), done_cnt, FW);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if ({axi_if.m_axi_arvalid, axi_if.m_axi_rready, pix_valid, pix_sof, busy, done, err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 0000000",
        {axi_if.m_axi_arvalid, axi_if.m_axi_rready, pix_valid, pix_sof, busy, done, err});
    end
    n_checks++;
    if (axi_if.m_axi_araddr !== BASE) begin
      n_fail++; $display("FAIL reset_araddr: got %08h, expected %08h", axi_if.m_axi_araddr, BASE);
    end
    n_checks++;
    if (axi_if.m_axi_arlen !== 8'd0 || pix_data !== 24'd0) begin
      n_fail++; $display("FAIL reset_arlen_pix: got %0d/%06h, expected 0/000000", axi_if.m_axi_arlen, pix_data);
    end
    n_checks++;
    if (axi_if.m_axi_arsize !== 3'b010 || axi_if.m_axi_arburst !== 2'b01) begin
      n_fail++; $display("FAIL ar_consts: got %b/%b, expected 010/01", axi_if.m_axi_arsize, axi_if.m_axi_arburst);
    end
    @(negedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_frame();
    clear_log();
    ready_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    n_checks++;
    if (axi_if.m_axi_arvalid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_cycle1: got arvalid=%b busy=%b, expected 0/1", axi_if.m_axi_arvalid, busy);
    end
    @(negedge clk); #2;
    n_checks++;
    if (axi_if.m_axi_arvalid !== 1'b1) begin
      n_fail++; $display("FAIL start_cycle2: got arvalid=%b, expected 1", axi_if.m_axi_arvalid);
    end
    wait_frame("frame");
    repeat (20) @(negedge clk);
    #2;
    n_checks++;
    if (ar_errors(NBURST) != 0) begin
      n_fail++; $display("FAIL frame_ar: got %0d bursts/%0d errors, expected %0d/0", ar_addr_q.size(), ar_errors(NBURST), NBURST);
    end
    n_checks++;
    if (pixel_errors() != 0) begin
      n_fail++; $display("FAIL frame_pixels: got %0d bad pixels, expected 0", pixel_errors());
    end
    n_checks++;
    if (done_cnt != 1 || busy_bad !== 1'b0) begin
      n_fail++; $display("FAIL frame_done: got %0d pulses busy_bad=%b, expected 1/0", done_cnt, busy_bad);
    end
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL frame_idle: got busy=%b err=%b, expected 0/0", busy, err);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    ready_mode = 0;
    pulse_start();
    repeat (400) @(negedge clk);
    #2;
    n_checks++;
    if (ar_addr_q.size() != FD / BL || axi_if.m_axi_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL stall_bursts: got %0d bursts arvalid=%b, expected %0d/0", ar_addr_q.size(), axi_if.m_axi_arvalid, FD / BL);
    end
    n_checks++;
    if (rx_data.size() != 0 || pix_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_pixels: got %0d popped valid=%b, expected 0/1", rx_data.size(), pix_valid);
    end
    ready_mode = 1;
    wait_frame("resume");
    n_checks++;
    if (ar_errors(NBURST) != 0 || pixel_errors() != 0) begin
      n_fail++; $display("FAIL resume_data: got %0d ar errors %0d bad pixels, expected 0/0", ar_errors(NBURST), pixel_errors());
    end
  endtask

  task automatic test_ar_delay();
    clear_log();
    ready_mode = 2;
    ar_delay = 5;
    pulse_start();
    wait_frame("ardelay");
    ar_delay = 0;
    n_checks++;
    if (ar_unstable !== 1'b0) begin
      n_fail++; $display("FAIL ardelay_stable: got unstable=%b, expected 0", ar_unstable);
    end
    n_checks++;
    if (ar_errors(NBURST) != 0 || pixel_errors() != 0) begin
      n_fail++; $display("FAIL ardelay_data: got %0d bursts %0d bad pixels, expected %0d/0", ar_addr_q.size(), pixel_errors(), NBURST);
    end
  endtask

  task automatic test_rresp_err();
    int cyc = 0;
    clear_log();
    ready_mode = 2;
    bad_resp_beat = 3;
    pulse_start();
    while (cyc < 500 && !bad_resp_sent) begin
      @(negedge clk); #2;
      cyc++;
    end
    n_checks++;
    if (err !== 1'b0 || !bad_resp_sent) begin
      n_fail++; $display("FAIL rresp_before: got err=%b sent=%b, expected 0/1", err, bad_resp_sent);
    end
    @(negedge clk); #2;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL rresp_after: got err=%b, expected 1", err);
    end
    wait_frame("rresp");
    bad_resp_beat = -1;
    n_checks++;
    if (pixel_errors() != 0 || err !== 1'b1 || done_cnt != 1) begin
      n_fail++; $display("FAIL rresp_frame: got %0d bad pixels err=%b done=%0d, expected 0/1/1", pixel_errors(), err, done_cnt);
    end
  endtask

  task automatic test_rlast_early();
    clear_log();
    ready_mode = 2;
    early_last_beat = 9;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear_on_start: got err=%b, expected 0", err);
    end
    wait_frame("rlast");
    early_last_beat = -1;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL rlast_err: got err=%b, expected 1", err);
    end
    n_checks++;
    if (ar_errors(NBURST) != 0 || pixel_errors() != 0) begin
      n_fail++; $display("FAIL rlast_data: got %0d ar errors %0d bad pixels, expected 0/0", ar_errors(NBURST), pixel_errors());
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    clear_log();
    ready_mode = 2;
    pulse_start();
    while (cyc < 500 && !(rx_data.size() >= 5 && axi_if.m_axi_rready === 1'b1)) begin
      @(negedge clk); #2;
      cyc++;
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({axi_if.m_axi_arvalid, axi_if.m_axi_rready, pix_valid, pix_sof, busy, done, err} !== 7'b0 ||
        axi_if.m_axi_rready !== 1'b0 || cyc >= 500) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b (waited %0d), expected 0000000",
        {axi_if.m_axi_arvalid, axi_if.m_axi_rready, pix_valid, pix_sof, busy, done, err}, cyc);
    end
    n_checks++;
    if (axi_if.m_axi_araddr !== BASE || axi_if.m_axi_arlen !== 8'd0 || pix_data !== 24'd0) begin
      n_fail++; $display("FAIL midreset_bus: got %08h/%0d/%06h, expected %08h/0/000000",
        axi_if.m_axi_araddr, axi_if.m_axi_arlen, pix_data, BASE);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    clear_log();
    pulse_start();
    wait_frame("refetch");
    n_checks++;
    if (ar_errors(NBURST) != 0 || pixel_errors() != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL refetch: got %0d ar errors %0d bad pixels %0d done, expected 0/0/1",
        ar_errors(NBURST), pixel_errors(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_ar_delay();
    test_rresp_err();
    test_rlast_early();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
